// File: rtl/ip_rx_crpr.sv
// Receive-side credit return: parses TLP headers, queues posted/non-posted credit records
// and drains them as spaced single-cycle pulses. Optional macro IP_CRPR_HOLD_EN adds cr_hold.
module ip_rx_crpr #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx_st,
  input  logic        rx_end,
  input  logic [15:0] rx_data,
`ifdef IP_CRPR_HOLD_EN
  input  logic        cr_hold,
`endif
  output logic        ph_cr,
  output logic        pd_cr,
  output logic [7:0]  pd_num,
  output logic        nph_cr,
  output logic        npd_cr,
  output logic        fifo_ovf
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, HDR1 = 2'd1, BODY = 2'd2} parse_t;
  typedef enum logic [1:0] {D_IDLE = 2'd0, D_PULSE = 2'd1, D_GAP = 2'd2} drain_t;

  // Returns {valid, posted, nonposted, has_data, pd_num}; pd_num wraps 256 to 0.
  function automatic logic [11:0] classify(input logic [1:0] fmt, input logic [4:0] typ,
                                           input logic [9:0] len);
    logic posted;
    logic nonposted;
    logic [7:0] num;
    posted    = 1'b0;
    nonposted = 1'b0;
    num       = 8'(({1'b0, len} + 11'd3) >> 2);
    casez (typ)
      5'b0000?: begin posted = fmt[1]; nonposted = ~fmt[1]; end
      5'b00010,
      5'b0010?: nonposted = 1'b1;
      5'b10???: posted = 1'b1;
      default:  begin posted = 1'b0; nonposted = 1'b0; end
    endcase
    return {posted | nonposted, posted, nonposted, fmt[1], num};
  endfunction

  parse_t      p_state_r, p_next_s;
  drain_t      d_state_r, d_next_s;
  logic [1:0]  fmt_r;
  logic [4:0]  type_r;
  logic [9:0]  len_r;
  logic        push_s, pop_s, push_ok_s, full_s, hold_s;
  logic [11:0] cls_s;
  logic [10:0] mem_r [FIFO_DEPTH];
  logic [10:0] head_s;
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic        ph_n_s, pd_n_s, nph_n_s, npd_n_s;
  logic [7:0]  pd_num_n_s;
  logic        unused_s;

  assign unused_s = rx_data[15];

`ifdef IP_CRPR_HOLD_EN
  assign hold_s = cr_hold;
`else
  assign hold_s = 1'b0;
`endif

  assign cls_s     = classify(fmt_r, type_r, len_r);
  assign full_s    = (cnt_r == CW'(FIFO_DEPTH));
  assign push_ok_s = push_s & (~full_s | pop_s);
  assign head_s    = mem_r[rd_ptr_r];

  // Parse state and header field capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p_state_r <= IDLE;
      fmt_r     <= 2'b00;
      type_r    <= 5'b00000;
      len_r     <= 10'd0;
    end else begin
      p_state_r <= p_next_s;
      if (rx_st) begin
        fmt_r  <= rx_data[14:13];
        type_r <= rx_data[12:8];
      end else if (p_state_r == HDR1 && !rx_end) begin
        len_r <= rx_data[9:0];
      end else begin
        len_r <= len_r;
      end
    end
  end

  // Parse next state; a new start always wins and silently abandons the old TLP
  always_comb begin
    p_next_s = p_state_r;
    push_s   = 1'b0;
    if (rx_st) begin
      p_next_s = HDR1;
    end else begin
      case (p_state_r)
        IDLE: p_next_s = IDLE;
        HDR1: p_next_s = rx_end ? IDLE : BODY;
        BODY: begin
          if (rx_end) begin
            p_next_s = IDLE;
            push_s   = cls_s[11];
          end else begin
            p_next_s = BODY;
          end
        end
        default: p_next_s = IDLE;
      endcase
    end
  end

  // Credit record FIFO and sticky overflow flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
      fifo_ovf <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 11'd0;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= cls_s[10:0];
        wr_ptr_r <= (wr_ptr_r == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PW'(FIFO_DEPTH - 1)) ? {PW{1'b0}} : rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
      if (push_s && full_s && !pop_s) fifo_ovf <= 1'b1;
    end
  end

  // Drain next state; outputs are loaded on the D_IDLE->D_PULSE transition
  always_comb begin
    d_next_s   = d_state_r;
    pop_s      = 1'b0;
    ph_n_s     = 1'b0;
    pd_n_s     = 1'b0;
    pd_num_n_s = 8'd0;
    nph_n_s    = 1'b0;
    npd_n_s    = 1'b0;
    case (d_state_r)
      D_IDLE: begin
        if (cnt_r != {CW{1'b0}} && !hold_s) begin
          d_next_s   = D_PULSE;
          pop_s      = 1'b1;
          ph_n_s     = head_s[10];
          pd_n_s     = head_s[10] & head_s[8];
          pd_num_n_s = (head_s[10] & head_s[8]) ? head_s[7:0] : 8'd0;
          nph_n_s    = head_s[9];
          npd_n_s    = head_s[9] & head_s[8];
        end else begin
          d_next_s = D_IDLE;
        end
      end
      D_PULSE: d_next_s = D_GAP;
      D_GAP:   d_next_s = D_IDLE;
      default: d_next_s = D_IDLE;
    endcase
  end

  // Drain state and registered credit outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      d_state_r <= D_IDLE;
      ph_cr     <= 1'b0;
      pd_cr     <= 1'b0;
      pd_num    <= 8'd0;
      nph_cr    <= 1'b0;
      npd_cr    <= 1'b0;
    end else begin
      d_state_r <= d_next_s;
      ph_cr     <= ph_n_s;
      pd_cr     <= pd_n_s;
      pd_num    <= pd_num_n_s;
      nph_cr    <= nph_n_s;
      npd_cr    <= npd_n_s;
    end
  end

endmodule

// File: tb/tb_ip_rx_crpr.sv
// Self-checking bench for ip_rx_crpr: directed classification/latency tables, a randomized
// scoreboard run, optional cr_hold overflow scenario, and reset with records pending.
module tb_ip_rx_crpr;

  logic        clk = 1'b0;
  logic        rstn, rx_st, rx_end;
  logic [15:0] rx_data;
`ifdef IP_CRPR_HOLD_EN
  logic        cr_hold;
`endif
  logic        ph_cr, pd_cr, nph_cr, npd_cr, fifo_ovf;
  logic [7:0]  pd_num;

  int checks = 0;
  int errors = 0;

  logic [11:0] exp_q[$];
  bit          mon_en = 1'b0;
  bit          prev_any = 1'b0;

  always #5 clk = ~clk;

  ip_rx_crpr #(.FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .rx_st(rx_st), .rx_end(rx_end), .rx_data(rx_data),
`ifdef IP_CRPR_HOLD_EN
    .cr_hold(cr_hold),
`endif
    .ph_cr(ph_cr), .pd_cr(pd_cr), .pd_num(pd_num), .nph_cr(nph_cr), .npd_cr(npd_cr),
    .fifo_ovf(fifo_ovf)
  );

  wire [11:0] obs = {ph_cr, pd_cr, pd_num, nph_cr, npd_cr};

  // Reference: expected pulse {ph,pd,pd_num,nph,npd} from the credit rules in plain arithmetic
  function automatic logic [11:0] model(input logic [1:0] fmt, input logic [4:0] typ,
                                        input int len, output bit ok);
    int  dwords, credits;
    bit  wd;
    logic [7:0] num;
    ok      = 1'b0;
    wd      = fmt[1];
    dwords  = (len == 0) ? 1024 : len;
    credits = (dwords + 3) / 4;
    num     = 8'(credits % 256);
    if (typ == 5'd0 || typ == 5'd1) begin
      ok = 1'b1;
      if (wd) return {1'b1, 1'b1, num, 1'b0, 1'b0};
      else    return {1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    end else if (typ == 5'd2 || typ == 5'd4 || typ == 5'd5) begin
      ok = 1'b1;
      return {1'b0, 1'b0, 8'h00, 1'b1, wd};
    end else if (typ >= 5'd16 && typ <= 5'd23) begin
      ok = 1'b1;
      return {1'b1, wd, wd ? num : 8'h00, 1'b0, 1'b0};
    end
    return 12'h000;
  endfunction

  // mode 0: complete TLP, 1: rx_end during HDR1, 2: never ended (later rx_st aborts it)
  task automatic send_tlp(input logic [1:0] fmt, input logic [4:0] typ, input logic [9:0] len,
                          input int nbody, input int mode);
    @(negedge clk);
    rx_st = 1'b1; rx_end = 1'b0; rx_data = {1'b0, fmt, typ, 8'h00};
    @(negedge clk);
    rx_st = 1'b0; rx_data = {6'h00, len}; rx_end = (mode == 1);
    if (mode != 1) begin
      for (int i = 0; i < nbody; i++) begin
        @(negedge clk);
        rx_data = 16'($urandom);
        rx_end  = (mode == 0 && i == nbody - 1);
      end
    end
    @(negedge clk);
    rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'h0000;
  endtask

  // Scoreboard monitor for the randomized run
  always @(negedge clk) begin
    if (mon_en) begin
      if (obs != 12'h000) begin
        checks++;
        if (prev_any) begin
          errors++;
          $display("FAIL spacing: pulse %h directly follows another pulse, required a zero cycle", obs);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got %h, required no pulse", obs);
        end else begin
          if (obs !== exp_q[0]) begin
            errors++;
            $display("FAIL pulse_value: got %h, required %h", obs, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      prev_any = (obs != 12'h000);
    end else begin
      prev_any = 1'b0;
    end
  end

  task automatic test_reset();
    rstn = 1'b0; rx_st = 1'b0; rx_end = 1'b0; rx_data = 16'h0000;
`ifdef IP_CRPR_HOLD_EN
    cr_hold = 1'b0;
`endif
    repeat (2) @(negedge clk);
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL reset_outputs: got %h, required 000", obs); end
    checks++;
    if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b, required 0", fifo_ovf); end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0]  fmt;
    logic [4:0]  typ;
    logic [9:0]  len;
    int          mode;
    logic [11:0] exp;
  } vec_t;

  task automatic test_classify();
    vec_t tbl[$];
    tbl.push_back('{2'b10, 5'b00000, 10'd1,    0, {1'b1, 1'b1, 8'd1,   1'b0, 1'b0}}); // MWr len1
    tbl.push_back('{2'b10, 5'b00000, 10'd0,    0, {1'b1, 1'b1, 8'd0,   1'b0, 1'b0}}); // MWr 1024 DW
    tbl.push_back('{2'b10, 5'b00000, 10'd9,    0, {1'b1, 1'b1, 8'd3,   1'b0, 1'b0}});
    tbl.push_back('{2'b11, 5'b00000, 10'd1021, 0, {1'b1, 1'b1, 8'd0,   1'b0, 1'b0}});
    tbl.push_back('{2'b11, 5'b00001, 10'd1020, 0, {1'b1, 1'b1, 8'd255, 1'b0, 1'b0}});
    tbl.push_back('{2'b00, 5'b00000, 10'd4,    0, {1'b0, 1'b0, 8'd0,   1'b1, 1'b0}}); // MRd
    tbl.push_back('{2'b10, 5'b00100, 10'd1,    0, {1'b0, 1'b0, 8'd0,   1'b1, 1'b1}}); // CfgWr0
    tbl.push_back('{2'b00, 5'b00010, 10'd1,    0, {1'b0, 1'b0, 8'd0,   1'b1, 1'b0}}); // IORd
    tbl.push_back('{2'b11, 5'b10000, 10'd5,    0, {1'b1, 1'b1, 8'd2,   1'b0, 1'b0}}); // MsgD
    tbl.push_back('{2'b01, 5'b10010, 10'd5,    0, {1'b1, 1'b0, 8'd0,   1'b0, 1'b0}}); // Msg
    tbl.push_back('{2'b10, 5'b01010, 10'd4,    0, 12'h000});                         // CplD
    tbl.push_back('{2'b10, 5'b00000, 10'd4,    1, 12'h000});                         // end in HDR1
    tbl.push_back('{2'b10, 5'b00000, 10'd4,    2, 12'h000});                         // abandoned
    tbl.push_back('{2'b10, 5'b00101, 10'd2,    0, {1'b0, 1'b0, 8'd0,   1'b1, 1'b1}}); // CfgWr1
    foreach (tbl[k]) begin
      send_tlp(tbl[k].fmt, tbl[k].typ, tbl[k].len, 2, tbl[k].mode);
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL classify_early[%0d]: got %h, required 000", k, obs); end
      @(negedge clk);
      checks++;
      if (obs !== tbl[k].exp) begin errors++; $display("FAIL classify[%0d]: got %h, required %h", k, obs, tbl[k].exp); end
      @(negedge clk);
      checks++;
      if (obs !== 12'h000) begin errors++; $display("FAIL classify_gap[%0d]: got %h, required 000", k, obs); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [4:0] picks [12] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd16, 5'd19, 5'd23, 5'd10, 5'd11, 5'd8, 5'd31};
    logic [1:0] fmt;
    logic [4:0] typ;
    logic [9:0] len;
    logic [11:0] e;
    int mode, wait_cnt;
    bit ok;
    exp_q.delete();
    mon_en = 1'b1;
    repeat (80) begin
      fmt  = 2'($urandom);
      typ  = ($urandom_range(0, 3) != 0) ? picks[$urandom_range(0, 11)] : 5'($urandom);
      len  = ($urandom_range(0, 4) == 0) ? 10'($urandom_range(1020, 1023) % 1024) : 10'($urandom);
      mode = ($urandom_range(0, 9) < 8) ? 0 : $urandom_range(1, 2);
      send_tlp(fmt, typ, len, $urandom_range(1, 3), mode);
      if (mode == 0) begin
        e = model(fmt, typ, int'(len), ok);
        if (ok) exp_q.push_back(e);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_cnt = 0;
    while (exp_q.size() != 0 && wait_cnt < 60) begin
      @(negedge clk);
      wait_cnt++;
    end
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL random_drain: %0d records outstanding, required 0", exp_q.size()); end
    checks++;
    if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL random_ovf: got %b, required 0", fifo_ovf); end
  endtask

`ifdef IP_CRPR_HOLD_EN
  task automatic test_hold();
    int pulses = 0;
    bit prev = 1'b0;
    bit seen_pulse = 1'b0;
    cr_hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_tlp(2'b10, 5'b00000, 10'(4 * (i + 1)), 1, 0);
      if (obs != 12'h000) seen_pulse = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (seen_pulse || obs != 12'h000) begin errors++; $display("FAIL hold_blocks: pulse while held, required none"); end
    checks++;
    if (fifo_ovf !== 1'b1) begin errors++; $display("FAIL hold_ovf: got %b, required 1", fifo_ovf); end
    cr_hold = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (obs != 12'h000) begin
        checks++;
        if (prev) begin errors++; $display("FAIL hold_spacing: back-to-back pulse %h", obs); end
        checks++;
        if (obs !== {1'b1, 1'b1, 8'(pulses + 1), 1'b0, 1'b0}) begin
          errors++; $display("FAIL hold_pulse[%0d]: got %h, required %h", pulses, obs, {1'b1, 1'b1, 8'(pulses + 1), 1'b0, 1'b0});
        end
        pulses++;
      end
      prev = (obs != 12'h000);
    end
    checks++;
    if (pulses != 4) begin errors++; $display("FAIL hold_count: got %0d pulses, required 4", pulses); end
  endtask
`endif

  task automatic test_reset_midop();
    int late = 0;
`ifdef IP_CRPR_HOLD_EN
    cr_hold = 1'b1;
`endif
    send_tlp(2'b10, 5'b00000, 10'd8, 1, 0);
    send_tlp(2'b00, 5'b00000, 10'd8, 1, 0);
    send_tlp(2'b11, 5'b10000, 10'd8, 1, 0);
    rx_st = 1'b1; rx_data = 16'h4000;
    #1 rstn = 1'b0;
    #1;
    checks++;
    if (obs !== 12'h000) begin errors++; $display("FAIL midop_reset_outputs: got %h, required 000", obs); end
    checks++;
    if (fifo_ovf !== 1'b0) begin errors++; $display("FAIL midop_reset_ovf: got %b, required 0", fifo_ovf); end
    @(negedge clk);
    rx_st = 1'b0; rx_data = 16'h0000;
    rstn = 1'b1;
`ifdef IP_CRPR_HOLD_EN
    cr_hold = 1'b0;
`endif
    repeat (20) begin
      @(negedge clk);
      if (obs != 12'h000) late++;
    end
    checks++;
    if (late != 0) begin errors++; $display("FAIL midop_no_pulse: got %0d pulse cycles, required 0", late); end
  endtask

  initial begin
    test_reset();
    test_classify();
    test_random();
`ifdef IP_CRPR_HOLD_EN
    test_hold();
`endif
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_rx_crpr.md
IP_RX_CRPR -- requirements
Module: ip_rx_crpr

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- rx_st  input  1  first 16-bit word of a received TLP is on rx_data.
- rx_end  input  1  last word of the TLP is on rx_data.
- rx_data  input  16  TLP word; word0[14:13]=fmt, word0[12:8]=type, word1[9:0]=length in DW.
- cr_hold  input  1  stall credit issue (present only with IP_CRPR_HOLD_EN).
- ph_cr  output  1  posted header credit pulse.
- pd_cr  output  1  posted data credit pulse.
- pd_num  output  8  posted data credit count; 0 with pd_cr=1 means 256.
- nph_cr  output  1  non-posted header credit pulse.
- npd_cr  output  1  non-posted data credit pulse.
- fifo_ovf  output  1  sticky: a credit record was dropped.
REQ-002 SHALL have the parameter FIFO_DEPTH, default 4, number of pending credit records.

Function
REQ-003 SHALL use a parse FSM with states IDLE, HDR1 and BODY.
REQ-004 SHALL latch word0 on rx_st in any state and go to HDR1; rx_st in HDR1 or BODY aborts the old TLP with no credit.
REQ-005 SHALL, in HDR1, latch word1[9:0] as length and go to BODY; rx_end in the HDR1 cycle aborts the TLP to IDLE with no credit.
REQ-006 SHALL, on rx_end in BODY, classify the TLP, push one record if creditable, and go to IDLE.
REQ-007 SHALL classify type 00000/00001 as memory: fmt[1]=1 is posted with data; fmt[1]=0 is non-posted without data.
REQ-008 SHALL classify type 00010 (IO) and 00100/00101 (Cfg) as non-posted, with data iff fmt[1]=1.
REQ-009 SHALL classify type[4:3]=10 (Msg) as posted, with data iff fmt[1]=1.
REQ-010 SHALL push no record for completions (01010/01011) or any other type.
REQ-011 SHALL compute posted data credits as (length+3)>>2 over 11 bits and truncate to 8 bits; length 0 (1024 DW) and length 1021..1023 both yield pd_num=0, meaning 256.
REQ-012 SHALL store each record in a FIFO of FIFO_DEPTH entries holding {posted, nonposted, has_data, pd_num}.
REQ-013 SHALL let a push and a pop in the same cycle both succeed, including when the FIFO is full.
REQ-014 SHALL drop a push to a full FIFO with no pop that cycle and set fifo_ovf, which stays set until reset.
REQ-015 SHALL use a drain FSM with states D_IDLE, D_PULSE and D_GAP:
- D_IDLE to D_PULSE when the FIFO is non-empty (and cr_hold=0 if built in); the head is popped.
- D_PULSE drives the outputs for exactly one cycle, then goes to D_GAP.
- D_GAP is exactly one cycle of all-zero outputs, then D_IDLE.
REQ-016 SHALL guarantee that any two credit pulses are at least one idle cycle apart, so back-to-back pulses never occur.
REQ-017 SHALL drive a posted record as ph_cr=1, pd_cr=has_data, pd_num=has_data?count:0, with nph_cr=npd_cr=0.
REQ-018 SHALL drive a non-posted record as nph_cr=1, npd_cr=has_data (one credit), with ph_cr=pd_cr=0 and pd_num=0.
REQ-019 SHALL register all outputs; latency from the rx_end edge to the pulse is 2 cycles when the FIFO is empty and not held.

Reset
REQ-020 SHALL, with rstn low, reset all outputs to 0, fifo_ovf to 0, the FIFO to empty, the parse FSM to IDLE and the drain FSM to D_IDLE.
REQ-021 SHALL discard any in-flight TLP and all pending records on reset mid-operation; no credit pulse is emitted afterwards for them.

Configuration
REQ-022 SHALL implement the macro IP_CRPR_HOLD_EN as follows:
- Defined: the cr_hold port exists; cr_hold=1 blocks D_IDLE to D_PULSE; a pulse already in D_PULSE or D_GAP completes.
- Undefined: cr_hold is absent and draining is unconditional.

Verification
REQ-023 SHALL cover these directed scenarios:
- MWr, fmt=10, len=1 -> ph_cr=1, pd_cr=1, pd_num=1, 2 cycles after rx_end.
- MWr, len=0 -> ph_cr=1, pd_cr=1, pd_num=0; MWr, len=9 -> pd_num=3.
- MRd -> nph_cr=1 only. CfgWr0 -> nph_cr=1 and npd_cr=1. MsgD -> ph_cr=1 and pd_cr=1.
- Completion, then rx_end during HDR1 -> no pulse on any output.
- (IP_CRPR_HOLD_EN) cr_hold=1 with 5 MWr TLPs -> fifo_ovf=1; release -> 4 pulses, each followed by a zero cycle.
- Reset asserted with 3 records pending -> all outputs 0, no later pulses.
